// File: rtl/loss_stream.sv
// loss_stream: streaming L1/L2/Huber loss accumulator followed by a restoring divider for the mean.
// Define LOSS_HUBER_EN to build the Huber datapath; without it mode 10 computes L1.
module loss_stream #(
  parameter int IL          = 4,
  parameter int FL          = 16,
  parameter int LANES       = 4,
  parameter int MAX_NUM     = 64,
  parameter int CW          = $clog2(MAX_NUM + 1),
  parameter int HUBER_DELTA = 1 << FL
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [1:0]                          mode,
  input  logic [CW-1:0]                       num,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [LANES-1:0][IL+FL-1:0]  yHat,
  input  logic signed [LANES-1:0][IL+FL-1:0]  y,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [IL+FL-1:0]             out,
  output logic                                sat,
  output logic [1:0]                          state
);
  localparam int W   = IL + FL;
  localparam int EW  = 2 * IL + FL + 2;
  localparam int AW  = EW + CW;
  localparam int PW  = 2 * W + 2;
  localparam int DCW = $clog2(AW + 1);

  localparam logic [CW-1:0]  NUM_MAX = CW'(MAX_NUM);
  localparam logic [CW-1:0]  LANES_C = CW'(LANES);
  localparam logic [W-1:0]   OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [DCW-1:0] DIV_END = DCW'(AW - 1);

  if (HUBER_DELTA <= 0) begin : g_bad_delta
    $error("loss_stream: HUBER_DELTA must be positive");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCUM  = 2'b01,
    S_DIVIDE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]     mode_reg;
  logic [CW-1:0]  num_reg;
  logic [CW-1:0]  rem_reg;
  logic [AW-1:0]  acc_reg;
  logic [CW-1:0]  div_rem_reg;
  logic [DCW-1:0] div_cnt_reg;
  logic [W-1:0]   out_reg;
  logic           sat_reg;

  logic [CW-1:0]  num_clamped;
  logic [CW-1:0]  rem_next;
  logic           last_beat;
  logic           beat;
  logic           div_last;

  assign num_clamped = (num > NUM_MAX) ? NUM_MAX : num;
  assign last_beat   = (rem_reg <= LANES_C);
  assign rem_next    = last_beat ? '0 : (rem_reg - LANES_C);
  assign beat        = in_valid && in_ready;
  assign div_last    = (div_cnt_reg == DIV_END);

  // Per-lane loss; lanes at or beyond the remaining count are forced to zero.
  logic [LANES-1:0][EW-1:0] lane_loss;
  logic [LANES-1:0]         lane_en;

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [W:0] d;
    logic [W:0]        ad;
    logic [PW-1:0]     ad_ext;
    logic [PW-1:0]     sq;
    logic [EW-1:0]     l1;
    logic [EW-1:0]     l2;
    logic [EW-1:0]     loss;
    logic              unused_bits;

    assign d      = {yHat[gi][W-1], yHat[gi]} - {y[gi][W-1], y[gi]};
    assign ad     = d[W] ? -d : d;
    assign ad_ext = {{(PW-W-1){1'b0}}, ad};
    assign sq     = ad_ext * ad_ext;
    assign l1     = {{(EW-W-1){1'b0}}, ad};
    assign l2     = sq[FL +: EW];

`ifdef LOSS_HUBER_EN
    localparam logic [PW-1:0] DELTA = PW'(HUBER_DELTA);
    localparam logic [PW-1:0] HALF  = PW'(HUBER_DELTA / 2);
    logic [PW-1:0] lin;
    logic [EW-1:0] hub;

    // Quadratic inside the threshold, linear (slope delta) outside.
    assign lin         = DELTA * (ad_ext - HALF);
    assign hub         = (ad_ext <= DELTA) ? {1'b0, sq[PW-1:FL+1]} : lin[FL +: EW];
    assign unused_bits = ^{sq[FL-1:0], lin[FL-1:0]};
`else
    assign unused_bits = ^sq[FL-1:0];
`endif

    always_comb begin
      case (mode_reg)
        2'b00:   loss = l1;
`ifdef LOSS_HUBER_EN
        2'b10:   loss = hub;
`else
        2'b10:   loss = l1;
`endif
        default: loss = l2;
      endcase
    end

    assign lane_en[gi]   = (rem_reg > CW'(gi));
    assign lane_loss[gi] = lane_en[gi] ? loss : '0;
  end

  logic [AW-1:0] lane_sum;
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + AW'(lane_loss[i]);
    end
  end

  // Restoring divider step; the quotient shifts into acc_reg as the dividend shifts out.
  logic [CW:0]   div_trial;
  logic [CW:0]   div_diff;
  logic          div_bit;
  logic [CW-1:0] div_rem_next;
  logic [AW-1:0] quo_next;
  logic          quo_sat;
  logic          div_unused;

  always_comb begin
    div_trial    = {div_rem_reg, acc_reg[AW-1]};
    div_diff     = div_trial - {1'b0, num_reg};
    div_bit      = (div_trial >= {1'b0, num_reg});
    div_rem_next = div_bit ? div_diff[CW-1:0] : div_trial[CW-1:0];
    quo_next     = {acc_reg[AW-2:0], div_bit};
    quo_sat      = |quo_next[AW-1:W-1];
  end

  assign div_unused = div_diff[CW] ^ div_trial[CW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (num_clamped == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_next = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (div_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg    <= '0;
      num_reg     <= '0;
      rem_reg     <= '0;
      acc_reg     <= '0;
      div_rem_reg <= '0;
      div_cnt_reg <= '0;
      out_reg     <= '0;
      sat_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            mode_reg    <= mode;
            num_reg     <= num_clamped;
            rem_reg     <= num_clamped;
            acc_reg     <= '0;
            div_rem_reg <= '0;
            div_cnt_reg <= '0;
            out_reg     <= '0;
            sat_reg     <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc_reg <= acc_reg + lane_sum;
            rem_reg <= rem_next;
          end
        end
        S_DIVIDE: begin
          acc_reg     <= quo_next;
          div_rem_reg <= div_rem_next;
          div_cnt_reg <= div_cnt_reg + DCW'(1);
          if (div_last) begin
            out_reg <= quo_sat ? OUT_MAX : quo_next[W-1:0];
            sat_reg <= quo_sat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out   = out_reg;
  assign sat   = sat_reg;
  assign state = state_reg;
endmodule

// File: tb/tb_loss_stream.sv
// Testbench for loss_stream: table of directed jobs plus hand sequences for reset and output back-pressure.
module tb_loss_stream;
  localparam int IL      = 4;
  localparam int FL      = 16;
  localparam int LANES   = 4;
  localparam int MAX_NUM = 64;
  localparam int CW      = 7;
  localparam int AW      = (2 * IL + FL + 2) + CW;  // 26 + 7 = 33 divide cycles

  localparam logic [19:0] P0_5 = 20'h08000;
  localparam logic [19:0] P1   = 20'h10000;
  localparam logic [19:0] P2   = 20'h20000;
  localparam logic [19:0] P3   = 20'h30000;
  localparam logic [19:0] P7   = 20'h70000;
  localparam logic [19:0] N0_5 = 20'hF8000;
  localparam logic [19:0] N1   = 20'hF0000;
  localparam logic [19:0] N7   = 20'h90000;

  typedef logic [63:0][19:0] elems_t;
  typedef struct packed {
    logic [1:0]  mode;
    logic [6:0]  num;
    logic        bub;
    elems_t      yh;
    elems_t      yv;
    logic [19:0] exp_out;
    logic        exp_sat;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [1:0]              mode;
  logic [CW-1:0]           num;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [3:0][19:0] yHat;
  logic signed [3:0][19:0] y;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [19:0]      out;
  logic                    sat;
  logic [1:0]              state;

  int n_tests = 0;
  int n_fail  = 0;

  loss_stream #(.IL(IL), .FL(FL), .LANES(LANES), .MAX_NUM(MAX_NUM)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num(num),
    .in_valid(in_valid), .in_ready(in_ready), .yHat(yHat), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input int hold, input string tag);
    int cyc, idx, beats, drive_cyc, first, n_eff;
    bit seen;
    logic [19:0] o;
    logic s;
    n_eff = (int'(v.num) > MAX_NUM) ? MAX_NUM : int'(v.num);
    cyc = 0; idx = 0; beats = 0; drive_cyc = -1; first = -1; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = v.mode; num = v.num; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc < 400) begin
      if (out_valid) begin
        seen = 1'b1;
        first = cyc;
      end else begin
        in_valid = 1'b0;
        if (in_ready && !(v.bub && (cyc % 3 == 1))) begin
          in_valid = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            yHat[l] = (idx + l < 64) ? v.yh[idx + l] : '0;
            y[l]    = (idx + l < 64) ? v.yv[idx + l] : '0;
          end
          idx += LANES;
          beats++;
          drive_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    o = out;
    s = sat;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid low after 400 cycles, required high", tag);
    end
    chk({tag, "_out"}, 32'(o), 32'(v.exp_out));
    chk({tag, "_sat"}, 32'(s), 32'(v.exp_sat));
    chk({tag, "_beats"}, beats, (n_eff + 3) / 4);
    if (n_eff > 0) chk({tag, "_lat"}, first - drive_cyc - 1, AW);
    else           chk({tag, "_lat"}, first, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_out"}, 32'(out), 32'(o));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_state"}, 32'(state), 32'd0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_out_held"}, 32'(out), 32'(o));
    $display("[TB] %s mode=%0d num=%0d out=%05h sat=%0d beats=%0d", tag, v.mode, v.num, o, s, beats);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; mode = '0; num = '0; in_valid = 1'b0; out_ready = 1'b0;
    yHat = '0; y = '0;

    // 0: L1 one beat, 4.5/4
    v = '0; v.mode = 2'b00; v.num = 7'd4;
    v.yh[0] = P1; v.yh[1] = P2; v.yh[2] = P0_5; v.yh[3] = N1;
    v.exp_out = 20'h12000; tbl[0] = v;
    // 1: L2 two beats with masked 7.0 garbage and input bubbles
    v = '0; v.mode = 2'b01; v.num = 7'd6; v.bub = 1'b1;
    for (int i = 0; i < 6; i++) v.yh[i] = P2;
    v.yh[6] = P7; v.yh[7] = P7;
    v.exp_out = 20'h40000; tbl[1] = v;
    // 2: L2 saturating
    v = '0; v.mode = 2'b01; v.num = 7'd1;
    for (int i = 0; i < 4; i++) begin v.yh[i] = P7; v.yv[i] = N7; end
    v.exp_out = 20'h7FFFF; v.exp_sat = 1'b1; tbl[2] = v;
    // 3: empty job
    v = '0; v.mode = 2'b00; v.num = 7'd0;
    v.yh[0] = P7; v.exp_out = 20'h00000; tbl[3] = v;
    // 4: mode 10, diffs {0.5, 3.0}
    v = '0; v.mode = 2'b10; v.num = 7'd2;
    v.yh[0] = P0_5; v.yh[1] = P3;
`ifdef LOSS_HUBER_EN
    v.exp_out = 20'h15000;
`else
    v.exp_out = 20'h1C000;
`endif
    tbl[4] = v;
    // 5: L1 negative diffs, floor(3.5/3)
    v = '0; v.mode = 2'b00; v.num = 7'd3;
    v.yv[0] = P1; v.yv[1] = P2; v.yv[2] = P0_5; v.yh[3] = P7;
    v.exp_out = 20'h12AAA; tbl[5] = v;
    // 6: reserved mode behaves as L2: (0.25 + 2.25)/2
    v = '0; v.mode = 2'b11; v.num = 7'd2;
    v.yh[0] = P0_5; v.yh[1] = P1; v.yv[1] = N0_5;
    v.exp_out = 20'h14000; tbl[6] = v;
    // 7: num above MAX_NUM clamps to 64 elements
    v = '0; v.mode = 2'b00; v.num = 7'd100;
    for (int i = 0; i < 64; i++) v.yh[i] = P1;
    v.exp_out = 20'h10000; tbl[7] = v;
    // 8: L2 with a sub-LSB square and floor(4.0/5)
    v = '0; v.mode = 2'b01; v.num = 7'd5;
    v.yh[0] = 20'h00001;
    for (int i = 1; i < 5; i++) v.yh[i] = P1;
    v.yh[5] = P7; v.yh[6] = P7; v.yh[7] = P7;
    v.exp_out = 20'h0CCCC; tbl[8] = v;

    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_job(tbl[i], 0, $sformatf("v%0d", i));
    end

    // Reset mid-ACCUM after one beat of large values.
    @(negedge clk);
    start = 1'b1; mode = 2'b01; num = 7'd8;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin yHat[l] = P7; y[l] = N7; end
    @(negedge clk);
    in_valid = 1'b0;
    chk("racc_pre_state", 32'(state), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("racc_state", 32'(state), 32'd0);
    chk("racc_in_ready", 32'(in_ready), 32'd0);
    chk("racc_out_valid", 32'(out_valid), 32'd0);
    chk("racc_out", 32'(out), 32'd0);
    chk("racc_sat", 32'(sat), 32'd0);
    $display("[TB] reset mid-ACCUM state=%0d", state);
    run_job(tbl[0], 0, "post_racc");

    // Reset mid-DIVIDE.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; num = 7'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin yHat[l] = P1; y[l] = '0; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdiv_pre_state", 32'(state), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rdiv_state", 32'(state), 32'd0);
    chk("rdiv_out_valid", 32'(out_valid), 32'd0);
    $display("[TB] reset mid-DIVIDE state=%0d", state);

    // Back-pressure in DONE, then reset clears the held result.
    run_job(tbl[2], 5, "hold");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("ridle_out", 32'(out), 32'd0);
    chk("ridle_sat", 32'(sat), 32'd0);
    $display("[TB] reset in IDLE out=%05h sat=%0d", out, sat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
